// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: display timing counters, coordinate request window and registered panel outputs
module vga_timing_ctrl #(
  parameter int H_SYNC   = 128,
  parameter int H_BACK   = 88,
  parameter int H_VALID  = 800,
  parameter int H_FRONT  = 40,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 32,
  parameter int V_VALID  = 480,
  parameter int V_FRONT  = 13,
  parameter int PIX_LEAD = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] color_data_in,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_req,
  output logic        frame_end,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [23:0] vga_rgb
);
  localparam int HA = H_SYNC + H_BACK;
  localparam int VA = V_SYNC + V_BACK;
  localparam logic [10:0] H_END  = 11'(HA + H_VALID + H_FRONT - 1);
  localparam logic [10:0] H_ACT0 = 11'(HA);
  localparam logic [10:0] H_ACT1 = 11'(HA + H_VALID - 1);
  localparam logic [10:0] H_REQ0 = 11'(HA - PIX_LEAD);
  localparam logic [10:0] H_REQ1 = 11'(HA + H_VALID - 1 - PIX_LEAD);
  localparam logic [10:0] H_SY   = 11'(H_SYNC);
  localparam logic [9:0]  V_END  = 10'(VA + V_VALID + V_FRONT - 1);
  localparam logic [9:0]  V_ACT0 = 10'(VA);
  localparam logic [9:0]  V_ACT1 = 10'(VA + V_VALID - 1);
  localparam logic [9:0]  V_SY   = 10'(V_SYNC);
  logic [10:0] cnt_h;
  logic [9:0]  cnt_v;
  logic        h_end;
  logic        v_act;
  logic        active;
  always_comb begin
    h_end     = cnt_h == H_END;
    v_act     = cnt_v >= V_ACT0 && cnt_v <= V_ACT1;
    active    = v_act && cnt_h >= H_ACT0 && cnt_h <= H_ACT1;
    pix_req   = v_act && cnt_h >= H_REQ0 && cnt_h <= H_REQ1;
    pix_x     = pix_req ? 10'(cnt_h - H_REQ0) : 10'h3FF;
    pix_y     = pix_req ? cnt_v - V_ACT0 : 10'h3FF;
    frame_end = h_end && cnt_v == V_END;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_h   <= '0;
      cnt_v   <= '0;
      vga_hs  <= 1'b0;
      vga_vs  <= 1'b0;
      vga_de  <= 1'b0;
      vga_rgb <= '0;
    end else begin
      cnt_h   <= h_end ? '0 : cnt_h + 11'd1;
      if (h_end) cnt_v <= frame_end ? '0 : cnt_v + 10'd1;
      vga_hs  <= cnt_h < H_SY;
      vga_vs  <= cnt_v < V_SY;
      vga_de  <= active;
      vga_rgb <= active ? color_data_in : 24'h000000;
    end
  end
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: scoreboard bench on a shrunken timing so several full frames fit in a short run
module tb_vga_timing_ctrl;
  localparam int HS = 10, HB = 6, HV = 40, HF = 4;
  localparam int VS = 3, VB = 4, VV = 10, VF = 3;
  localparam int LEAD = 1;
  localparam int HA = HS + HB, VA = VS + VB;
  localparam int HT = HA + HV + HF, VT = VA + VV + VF;
  localparam int FRAME = HT * VT;
  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [23:0] rgb;
  } reg_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        white = 1'b0;
  logic        en = 1'b0;
  logic [23:0] color_data_in = '0;
  logic [23:0] pend = '0;
  logic [9:0]  pix_x, pix_y;
  logic        pix_req, frame_end, vga_hs, vga_vs, vga_de;
  logic [23:0] vga_rgb;
  logic        e_req, e_fe;
  logic [9:0]  e_x, e_y;
  reg_t        sb[$];
  reg_t        cur = '0;
  int          mh = 0, mv = 0;
  int          checks = 0, errors = 0;
  vga_timing_ctrl #(
    .H_SYNC(HS), .H_BACK(HB), .H_VALID(HV), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_VALID(VV), .V_FRONT(VF), .PIX_LEAD(LEAD)
  ) dut (
    .clk(clk), .rst(rst), .color_data_in(color_data_in),
    .pix_x(pix_x), .pix_y(pix_y), .pix_req(pix_req), .frame_end(frame_end),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de), .vga_rgb(vga_rgb)
  );
  always #5 clk = ~clk;
  function automatic logic m_act(int h, int v);
    return h >= HA && h <= HA + HV - 1 && v >= VA && v <= VA + VV - 1;
  endfunction
  function automatic logic m_req(int h, int v);
    return h >= HA - LEAD && h <= HA + HV - 1 - LEAD && v >= VA && v <= VA + VV - 1;
  endfunction
  assign e_req = m_req(mh, mv);
  assign e_fe  = mh == HT - 1 && mv == VT - 1;
  assign e_x   = e_req ? 10'(mh - HA + LEAD) : 10'h3FF;
  assign e_y   = e_req ? 10'(mv - VA) : 10'h3FF;
  // reference counters; each edge pushes what the registered outputs must show afterwards
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mh <= 0;
      mv <= 0;
      sb.delete();
      sb.push_back('0);
    end else begin
      sb.push_back({mh < HS, mv < VS, m_act(mh, mv),
                    m_act(mh, mv) ? (white ? 24'hFFFFFF : {8'(mh - HA), 8'(mv - VA), 8'hA5}) : 24'h0});
      mh <= mh == HT - 1 ? 0 : mh + 1;
      if (mh == HT - 1) mv <= mv == VT - 1 ? 0 : mv + 1;
    end
  end
  always @(negedge clk) begin
    if (en) begin
      if (sb.size() > 0) cur = sb.pop_front();
      checks += 2;
      if ({vga_hs, vga_vs, vga_de, vga_rgb} !== cur) begin
        errors++;
        $display("FAIL reg_out h=%0d v=%0d got %h exp %h", mh, mv, {vga_hs, vga_vs, vga_de, vga_rgb}, cur);
      end
      if ({pix_req, frame_end, pix_x, pix_y} !== {e_req, e_fe, e_x, e_y}) begin
        errors++;
        $display("FAIL comb_out h=%0d v=%0d got req=%b fe=%b x=%h y=%h exp req=%b fe=%b x=%h y=%h",
                 mh, mv, pix_req, frame_end, pix_x, pix_y, e_req, e_fe, e_x, e_y);
      end
    end
  end
  // color source with one clock of latency from the coordinate request
  initial forever begin
    @(negedge clk);
    pend = {pix_x[7:0], pix_y[7:0], 8'hA5};
    @(posedge clk);
    #1 color_data_in = white ? 24'hFFFFFF : pend;
  end
  task automatic wait_at(input int h, input int v, output bit hit);
    hit = 0;
    for (int i = 0; i < 2 * FRAME && !hit; i++) begin
      @(negedge clk);
      hit = mh == h && mv == v;
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    en = 1'b1;
    checks++;
    if ({vga_hs, vga_vs, vga_de, vga_rgb, pix_req, frame_end} !== '0 || pix_x !== 10'h3FF || pix_y !== 10'h3FF) begin
      errors++;
      $display("FAIL reset_state got hs=%b vs=%b de=%b rgb=%h req=%b fe=%b x=%h y=%h exp zeros and x=y=3ff",
               vga_hs, vga_vs, vga_de, vga_rgb, pix_req, frame_end, pix_x, pix_y);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({vga_hs, vga_vs, vga_de} !== 3'b110) begin
      errors++;
      $display("FAIL reset_release got hs/vs/de=%b exp 110", {vga_hs, vga_vs, vga_de});
    end
  endtask
  task automatic test_sync;
    int hs_hi = 0, vs_hi = 0, hs_up = 0, vs_up = 0;
    logic ph, pv;
    @(negedge clk);
    ph = vga_hs;
    pv = vga_vs;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      hs_hi += int'(vga_hs);
      vs_hi += int'(vga_vs);
      hs_up += int'(vga_hs && !ph);
      vs_up += int'(vga_vs && !pv);
      ph = vga_hs;
      pv = vga_vs;
    end
    checks += 4;
    if (hs_hi != 2 * VT * HS) begin errors++; $display("FAIL hs_high got %0d exp %0d", hs_hi, 2 * VT * HS); end
    if (vs_hi != 2 * VS * HT) begin errors++; $display("FAIL vs_high got %0d exp %0d", vs_hi, 2 * VS * HT); end
    if (hs_up != 2 * VT) begin errors++; $display("FAIL hs_pulses got %0d exp %0d", hs_up, 2 * VT); end
    if (vs_up != 2) begin errors++; $display("FAIL vs_pulses got %0d exp 2", vs_up); end
  endtask
  task automatic test_coords;
    bit hit;
    wait_at(HA - LEAD, VA, hit);
    checks++;
    if (!hit || pix_x !== 10'd0 || pix_y !== 10'd0 || pix_req !== 1'b1) begin
      errors++;
      $display("FAIL coord_first hit=%b got x=%h y=%h req=%b exp 000 000 1", hit, pix_x, pix_y, pix_req);
    end
    wait_at(HA + HV - 1 - LEAD, VA, hit);
    checks++;
    if (!hit || pix_x !== 10'(HV - 1) || pix_req !== 1'b1) begin
      errors++;
      $display("FAIL coord_last hit=%b got x=%h req=%b exp %h 1", hit, pix_x, pix_req, 10'(HV - 1));
    end
    @(negedge clk);
    checks++;
    if (pix_x !== 10'h3FF || pix_req !== 1'b0) begin
      errors++;
      $display("FAIL coord_after got x=%h req=%b exp 3ff 0", pix_x, pix_req);
    end
    wait_at(HA, VA + VV - 1, hit);
    checks++;
    if (!hit || pix_y !== 10'(VV - 1)) begin
      errors++;
      $display("FAIL row_last hit=%b got y=%h exp %h", hit, pix_y, 10'(VV - 1));
    end
    wait_at(HA, VA + VV, hit);
    checks++;
    if (!hit || pix_y !== 10'h3FF || pix_req !== 1'b0) begin
      errors++;
      $display("FAIL row_after hit=%b got y=%h req=%b exp 3ff 0", hit, pix_y, pix_req);
    end
  endtask
  task automatic test_pattern;
    bit hit;
    int de_n = 0, lines = 0;
    logic prev = 1'b0;
    logic [23:0] first = '0, last = '0;
    wait_at(0, 0, hit);
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (vga_de) begin
        de_n++;
        if (!prev) lines++;
        if (de_n == 1) first = vga_rgb;
        last = vga_rgb;
      end
      prev = vga_de;
    end
    checks += 4;
    if (!hit || de_n != HV * VV) begin errors++; $display("FAIL de_count hit=%b got %0d exp %0d", hit, de_n, HV * VV); end
    if (lines != VV) begin errors++; $display("FAIL de_lines got %0d exp %0d", lines, VV); end
    if (first !== 24'h0000A5) begin errors++; $display("FAIL rgb_first got %h exp 0000a5", first); end
    if (last !== {8'(HV - 1), 8'(VV - 1), 8'hA5}) begin
      errors++;
      $display("FAIL rgb_last got %h exp %h", last, {8'(HV - 1), 8'(VV - 1), 8'hA5});
    end
  endtask
  task automatic test_blank;
    bit hit;
    wait_at(0, 0, hit);
    white = 1'b1;
    checks++;
    if (!hit) begin errors++; $display("FAIL blank_sync got no frame start exp one"); end
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      checks++;
      if (vga_rgb !== (vga_de ? 24'hFFFFFF : 24'h0)) begin
        errors++;
        $display("FAIL blank_rgb h=%0d v=%0d de=%b got %h", mh, mv, vga_de, vga_rgb);
      end
    end
    white = 1'b0;
  endtask
  task automatic test_frame_end;
    bit hit;
    int n = 0, bad = 0;
    logic prev = 1'b0;
    wait_at(0, 0, hit);
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (frame_end) begin
        n++;
        if (mh != HT - 1 || mv != VT - 1 || prev) bad++;
      end
      prev = frame_end;
    end
    checks += 2;
    if (!hit || n != 3) begin errors++; $display("FAIL frame_end_count hit=%b got %0d exp 3", hit, n); end
    if (bad != 0) begin errors++; $display("FAIL frame_end_place got %0d misplaced exp 0", bad); end
  endtask
  task automatic test_mid_reset;
    bit hit;
    wait_at(30, 10, hit);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (!hit || {vga_hs, vga_vs, vga_de, vga_rgb, pix_req, frame_end} !== '0 || pix_x !== 10'h3FF || pix_y !== 10'h3FF) begin
      errors++;
      $display("FAIL mid_reset hit=%b got hs=%b vs=%b de=%b rgb=%h req=%b x=%h y=%h exp zeros x=y=3ff",
               hit, vga_hs, vga_vs, vga_de, vga_rgb, pix_req, pix_x, pix_y);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({vga_hs, vga_vs, vga_de} !== 3'b110) begin
      errors++;
      $display("FAIL mid_reset_release got hs/vs/de=%b exp 110", {vga_hs, vga_vs, vga_de});
    end
    test_sync();
  endtask
  initial begin
    test_reset();
    test_sync();
    test_coords();
    test_pattern();
    test_blank();
    test_frame_end();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL timeout got no end of run exp finish");
    $fatal(1, "timeout");
  end
endmodule
